// File: rtl/vga_fml_arbiter.sv
// ---------------------------------------------------------------------------
// vga_fml_arbiter
//
// Purpose: shares one FML slave port (the SDRAM controller's video channel)
// between the VGA LCD refresh master and the VGA CPU memory master. The LCD
// master wins ties because it is real-time. A run-length guard lets the CPU
// in after lcd_max_run consecutive LCD grants made while the CPU was waiting.
// A grant is held for the whole burst: address phase plus burst_len beats.
//
// Parameters:
//   fml_depth   - FML byte-address width
//   burst_len   - data beats per FML transaction (>= 2)
//   lcd_max_run - consecutive LCD grants allowed while CPU is pending (>= 1)
//
// Ports:
//   sys_clk, sys_rst_n       - clock (rising edge), async active-low reset
//   cpu_fml_* / lcd_fml_*    - the two FML master ports (adr/stb/we/sel/do in,
//                              ack/di out)
//   fml_*                    - FML slave port (adr/stb/we/sel/do out,
//                              ack/di in)
//   gnt_lcd, gnt_cpu         - current owner of the slave port, for debug
// ---------------------------------------------------------------------------
module vga_fml_arbiter #(
  parameter int fml_depth   = 20,
  parameter int burst_len   = 4,
  parameter int lcd_max_run = 8
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,

  input  logic [fml_depth-1:0] cpu_fml_adr,
  input  logic                 cpu_fml_stb,
  input  logic                 cpu_fml_we,
  input  logic [1:0]           cpu_fml_sel,
  input  logic [15:0]          cpu_fml_do,
  output logic                 cpu_fml_ack,
  output logic [15:0]          cpu_fml_di,

  input  logic [fml_depth-1:0] lcd_fml_adr,
  input  logic                 lcd_fml_stb,
  input  logic                 lcd_fml_we,
  input  logic [1:0]           lcd_fml_sel,
  input  logic [15:0]          lcd_fml_do,
  output logic                 lcd_fml_ack,
  output logic [15:0]          lcd_fml_di,

  output logic [fml_depth-1:0] fml_adr,
  output logic                 fml_stb,
  output logic                 fml_we,
  output logic [1:0]           fml_sel,
  output logic [15:0]          fml_do,
  input  logic                 fml_ack,
  input  logic [15:0]          fml_di,

  output logic                 gnt_lcd,
  output logic                 gnt_cpu
);

  localparam int RUN_W  = $clog2(lcd_max_run + 1);
  localparam int BEAT_W = (burst_len > 1) ? $clog2(burst_len) : 1;

  localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(lcd_max_run);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(burst_len - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LCD_ADR = 2'd1,
    CPU_ADR = 2'd2,
    DATA    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                owner_lcd_q, owner_lcd_d;   // owner during DATA
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [RUN_W-1:0]    run_cnt_q, run_cnt_d;

  // Guard trips when the CPU is waiting and LCD has already used its run.
  logic guard_trip;
  assign guard_trip = cpu_fml_stb && (run_cnt_q == RUN_MAX);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      owner_lcd_q <= 1'b0;
      beat_q      <= '0;
      run_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_lcd_q <= owner_lcd_d;
      beat_q      <= beat_d;
      run_cnt_q   <= run_cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    owner_lcd_d = owner_lcd_q;
    beat_d      = beat_q;
    run_cnt_d   = run_cnt_q;

    case (state_q)
      IDLE: begin
        if (lcd_fml_stb && !guard_trip) begin
          state_d     = LCD_ADR;
          owner_lcd_d = 1'b1;
          // Only LCD grants that made the CPU wait count towards the run.
          if (cpu_fml_stb) begin
            if (run_cnt_q != RUN_MAX) begin
              run_cnt_d = run_cnt_q + 1'b1;
            end
          end else begin
            run_cnt_d = '0;
          end
        end else if (cpu_fml_stb) begin
          state_d     = CPU_ADR;
          owner_lcd_d = 1'b0;
          run_cnt_d   = '0;
        end
      end

      LCD_ADR, CPU_ADR: begin
        if (fml_ack) begin
          state_d = DATA;
          beat_d  = '0;
        end
      end

      DATA: begin
        if (beat_q == BEAT_LAST) begin
          state_d = IDLE;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output steering
  // -------------------------------------------------------------------------
  logic in_lcd_adr, in_cpu_adr, in_data;
  assign in_lcd_adr = (state_q == LCD_ADR);
  assign in_cpu_adr = (state_q == CPU_ADR);
  assign in_data    = (state_q == DATA);

  assign gnt_lcd = in_lcd_adr || (in_data && owner_lcd_q);
  assign gnt_cpu = in_cpu_adr || (in_data && !owner_lcd_q);

  // Address and direction only matter during the address phase; write data
  // and byte enables are steered for the whole grant because write beat 0
  // coincides with the ack cycle.
  always_comb begin
    fml_stb = 1'b0;
    fml_adr = '0;
    fml_we  = 1'b0;
    fml_sel = 2'b00;
    fml_do  = 16'h0000;

    if (in_lcd_adr) begin
      fml_stb = 1'b1;
      fml_adr = lcd_fml_adr;
      fml_we  = lcd_fml_we;
    end else if (in_cpu_adr) begin
      fml_stb = 1'b1;
      fml_adr = cpu_fml_adr;
      fml_we  = cpu_fml_we;
    end

    if (gnt_lcd) begin
      fml_sel = lcd_fml_sel;
      fml_do  = lcd_fml_do;
    end else if (gnt_cpu) begin
      fml_sel = cpu_fml_sel;
      fml_do  = cpu_fml_do;
    end
  end

  // Slave ack is forwarded without delay, and only during the address phase.
  assign lcd_fml_ack = in_lcd_adr && fml_ack;
  assign cpu_fml_ack = in_cpu_adr && fml_ack;

  assign lcd_fml_di = fml_di;
  assign cpu_fml_di = fml_di;

endmodule

// File: tb/tb_vga_fml_arbiter.sv
module tb_vga_fml_arbiter;

  localparam int AW   = 20;
  localparam int BL   = 4;
  localparam int MAXR = 8;

  localparam logic [AW-1:0] LA   = 20'hA5A5A;
  localparam logic [AW-1:0] CA   = 20'h3C3C3;
  localparam logic [1:0]    LSEL = 2'b11;
  localparam logic [1:0]    CSEL = 2'b01;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] cadr, ladr;
  logic          cstb, lstb, cwe, lwe;
  logic [1:0]    csel, lsel;
  logic [15:0]   cdo, ldo;
  logic          cack, lack;
  logic [15:0]   cdi, ldi;
  logic [AW-1:0] fadr;
  logic          fstb, fwe;
  logic [1:0]    fsel;
  logic [15:0]   fdo;
  logic          fack;
  logic [15:0]   fdi;
  logic          gl, gc;

  int checks   = 0;
  int failures = 0;

  vga_fml_arbiter #(
    .fml_depth  (AW),
    .burst_len  (BL),
    .lcd_max_run(MAXR)
  ) dut (
    .sys_clk    (clk),
    .sys_rst_n  (rst_n),
    .cpu_fml_adr(cadr),
    .cpu_fml_stb(cstb),
    .cpu_fml_we (cwe),
    .cpu_fml_sel(csel),
    .cpu_fml_do (cdo),
    .cpu_fml_ack(cack),
    .cpu_fml_di (cdi),
    .lcd_fml_adr(ladr),
    .lcd_fml_stb(lstb),
    .lcd_fml_we (lwe),
    .lcd_fml_sel(lsel),
    .lcd_fml_do (ldo),
    .lcd_fml_ack(lack),
    .lcd_fml_di (ldi),
    .fml_adr    (fadr),
    .fml_stb    (fstb),
    .fml_we     (fwe),
    .fml_sel    (fsel),
    .fml_do     (fdo),
    .fml_ack    (fack),
    .fml_di     (fdi),
    .gnt_lcd    (gl),
    .gnt_cpu    (gc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {20'd0, fstb, gl, gc, lack, cack, fwe, fsel, fadr, fdo};
  endfunction

  // Pulse reset across two falling edges, releasing on a falling edge.
  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // -------------------------------------------------------------------------
  // Directed table: one record per cycle straight after reset release
  // -------------------------------------------------------------------------
  typedef struct {
    logic        lstb;
    logic        cstb;
    logic        ack;
    logic [15:0] di;
    logic        e_stb;
    logic        e_gl;
    logic        e_gc;
    logic        e_lack;
    logic        e_cack;
  } vec_t;

  vec_t tbl[16];

  // -------------------------------------------------------------------------
  // Reference model for the random phase: one transaction at a time, the
  // port is either free, in its address phase, or counting down data beats.
  // -------------------------------------------------------------------------
  int m_owner;   // 0 free, 1 LCD, 2 CPU
  bit m_acked;
  int m_beats;
  int m_run;

  initial begin
    logic e_stb, e_lack, e_cack;
    logic [AW-1:0] e_adr;
    logic e_we;
    logic [1:0] e_sel;
    logic [15:0] e_do;
    int n_owner, n_beats, n_run;
    bit n_acked;
    int txn;
    int grants[$];
    int n, lcd_after, phase;
    bit done, raise;

    // table contents
    //                 lstb cstb ack di       stb gl gc la ca
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 16'h1111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 16'h2222, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 16'h3333, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 16'h4444, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // ---------------- reset with both requests high ----------------------
    rst_n = 1'b0;
    ladr = LA;  lwe = 1'b0; lsel = LSEL; ldo = 16'hBEEF; lstb = 1'b1;
    cadr = CA;  cwe = 1'b1; csel = CSEL; cdo = 16'hC000; cstb = 1'b1;
    fack = 1'b1; fdi = 16'h0000;
    repeat (3) @(negedge clk);
    chk("reset_outs", all_outs(), 64'd0);
    chk("reset_di", {32'd0, ldi, cdi}, 64'd0);
    rst_n = 1'b1;

    // ---------------- table-driven directed sequence ----------------------
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      lstb = tbl[i].lstb;
      cstb = tbl[i].cstb;
      fack = tbl[i].ack;
      fdi  = tbl[i].di;
      cdo  = 16'hC000 + 16'(i);
      ldo  = 16'hD000 + 16'(i);
      @(negedge clk);
      chk($sformatf("tbl%0d_stb", i), fstb, tbl[i].e_stb);
      chk($sformatf("tbl%0d_gnt", i), {gl, gc}, {tbl[i].e_gl, tbl[i].e_gc});
      chk($sformatf("tbl%0d_ack", i), {lack, cack}, {tbl[i].e_lack, tbl[i].e_cack});
      chk($sformatf("tbl%0d_adr", i), fadr,
          tbl[i].e_stb ? (tbl[i].e_gl ? LA : CA) : 20'd0);
      chk($sformatf("tbl%0d_we", i), fwe, tbl[i].e_stb && tbl[i].e_gc);
      chk($sformatf("tbl%0d_mux", i), {fsel, fdo},
          tbl[i].e_gl ? {LSEL, ldo} : tbl[i].e_gc ? {CSEL, cdo} : 18'd0);
      chk($sformatf("tbl%0d_di", i), {ldi, cdi}, {tbl[i].di, tbl[i].di});
      $display("tbl %0d: stb=%b gl=%b gc=%b lack=%b cack=%b adr=%h do=%h di=%h",
               i, fstb, gl, gc, lack, cack, fadr, fdo, ldi);
    end

    // ---------------- contention: both held, slave always acks -----------
    lstb = 1'b1; cstb = 1'b1; fack = 1'b1;
    do_reset();
    for (int cyc = 0; cyc < 400 && grants.size() < 27; cyc++) begin
      @(negedge clk);
      if (fstb) begin
        grants.push_back(gc ? 2 : 1);
        $display("contention grant %0d: %s", grants.size() - 1, gc ? "CPU" : "LCD");
      end
    end
    chk("contention_count", grants.size(), 27);
    foreach (grants[k]) begin
      chk($sformatf("contention_grant%0d", k), grants[k], ((k % 9) == 8) ? 2 : 1);
    end

    // ---------------- LCD streaming, then CPU raised mid-burst ------------
    lstb = 1'b1; cstb = 1'b0; fack = 1'b1;
    do_reset();
    n = 0; lcd_after = 0; phase = 0; done = 1'b0; raise = 1'b0;
    for (int cyc = 0; cyc < 600 && !done; cyc++) begin
      @(posedge clk);
      #1;
      if (raise) begin
        cstb  = 1'b1;
        raise = 1'b0;
      end
      @(negedge clk);
      if (fstb) begin
        if (phase == 0) begin
          n++;
          chk($sformatf("stream_grant%0d", n), {gl, gc}, 2'b10);
          if (n == 20) begin
            phase = 1;
            raise = 1'b1;
          end
        end else if (gc) begin
          chk("stream_lcd_before_cpu", lcd_after, MAXR);
          done = 1'b1;
        end else begin
          lcd_after++;
        end
      end
    end
    chk("stream_done", done, 1'b1);

    // ---------------- LCD drops stb: CPU granted at once -----------------
    lstb = 1'b1; cstb = 1'b0; fack = 1'b1;
    do_reset();
    done = 1'b0;
    for (int cyc = 0; cyc < 10 && !done; cyc++) begin
      @(negedge clk);
      if (fstb && gl) done = 1'b1;
    end
    chk("drop_lcd_grant", done, 1'b1);
    @(posedge clk);
    #1 lstb = 1'b0; cstb = 1'b1;
    done = 1'b0;
    for (int cyc = 0; cyc < 10 && !done; cyc++) begin
      @(negedge clk);
      if (fstb) begin
        chk("drop_next_is_cpu", {gl, gc}, 2'b01);
        done = 1'b1;
      end
    end
    chk("drop_cpu_seen", done, 1'b1);

    // ---------------- reset during DATA beat 2 ---------------------------
    lstb = 1'b1; cstb = 1'b0; fack = 1'b1; ldo = 16'h5A5A;
    do_reset();
    done = 1'b0;
    for (int cyc = 0; cyc < 10 && !done; cyc++) begin
      @(negedge clk);
      if (fstb) done = 1'b1;
    end
    chk("rstdata_adr_seen", done, 1'b1);
    lstb = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rstdata_before", {gl, fsel, fdo}, {1'b1, LSEL, 16'h5A5A});
    rst_n = 1'b0;
    #1;
    chk("rstdata_outs", all_outs(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cstb = 1'b1;
    fack = 1'b0;
    #1;
    chk("rstdata_idle", {fstb, gl, gc}, 3'b000);
    @(posedge clk);
    #1;
    chk("rstdata_next", {fstb, gc, fadr}, {1'b1, 1'b1, CA});
    @(negedge clk);
    fack = 1'b1;
    #1;
    chk("rstdata_next_ack", {cack, lack}, 2'b10);

    // ---------------- randomized run against the model -------------------
    lstb = 1'b0; cstb = 1'b0; fack = 1'b0;
    do_reset();
    m_owner = 0; m_acked = 1'b0; m_beats = 0; m_run = 0;
    txn = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      // expected outputs for this cycle
      e_stb  = (m_owner != 0) && !m_acked;
      e_adr  = e_stb ? ((m_owner == 1) ? ladr : cadr) : 20'd0;
      e_we   = e_stb ? ((m_owner == 1) ? lwe : cwe) : 1'b0;
      e_sel  = (m_owner == 1) ? lsel : (m_owner == 2) ? csel : 2'b00;
      e_do   = (m_owner == 1) ? ldo  : (m_owner == 2) ? cdo  : 16'h0000;
      e_lack = e_stb && (m_owner == 1) && fack;
      e_cack = e_stb && (m_owner == 2) && fack;
      chk($sformatf("rnd%0d_stb", cyc), fstb, e_stb);
      chk($sformatf("rnd%0d_gnt", cyc), {gl, gc}, {m_owner == 1, m_owner == 2});
      chk($sformatf("rnd%0d_ack", cyc), {lack, cack}, {e_lack, e_cack});
      chk($sformatf("rnd%0d_adr", cyc), {fwe, fadr}, {e_we, e_adr});
      chk($sformatf("rnd%0d_mux", cyc), {fsel, fdo, ldi, cdi}, {e_sel, e_do, fdi, fdi});
      if (e_lack || e_cack) begin
        txn++;
        $display("rnd txn %0d: %s adr=%h we=%b", txn, e_lack ? "LCD" : "CPU", e_adr, e_we);
      end

      // model step
      n_owner = m_owner; n_acked = m_acked; n_beats = m_beats; n_run = m_run;
      if (m_owner == 0) begin
        if (lstb && !(cstb && m_run == MAXR)) begin
          n_owner = 1;
          n_run   = cstb ? ((m_run < MAXR) ? m_run + 1 : MAXR) : 0;
        end else if (cstb) begin
          n_owner = 2;
          n_run   = 0;
        end
      end else if (!m_acked) begin
        if (fack) begin
          n_acked = 1'b1;
          n_beats = BL;
        end
      end else begin
        n_beats = m_beats - 1;
        if (n_beats == 0) begin
          n_owner = 0;
          n_acked = 1'b0;
        end
      end

      @(posedge clk);
      m_owner = n_owner; m_acked = n_acked; m_beats = n_beats; m_run = n_run;
      #1;
      // masters: hold request until acked, then maybe issue another
      if ((lstb && e_lack) || !lstb) begin
        lstb = lstb ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
        if (lstb) begin
          ladr = AW'($urandom);
          lwe  = 1'($urandom);
          lsel = 2'($urandom);
        end
      end
      if ((cstb && e_cack) || !cstb) begin
        cstb = cstb ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
        if (cstb) begin
          cadr = AW'($urandom);
          cwe  = 1'($urandom);
          csel = 2'($urandom);
        end
      end
      ldo  = 16'($urandom);
      cdo  = 16'($urandom);
      fack = ($urandom_range(0, 2) == 0);
      fdi  = 16'($urandom);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
